// File: rtl/tick_bcd_counter.sv
// Two-digit BCD tick counter, modulo MOD, with terminal-count output for cascading.
// Define TICK_BCD_SAT_EN to saturate at MOD-1 with a level tc instead of wrapping.
module tick_bcd_counter #(
  parameter int MOD  = 60,
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       clr,
  input  logic       en,
  input  logic       tick,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       tc
);

  localparam int         LAST   = MOD - 1;
  localparam logic [3:0] LAST_T = 4'(LAST / 10);
  localparam logic [3:0] LAST_U = 4'(LAST % 10);

  logic [7:0] count_q, count_d;
  logic       tc_q, tc_d;
  logic       tick_q;
  logic       inc;
  logic       at_last;

  // Loads that are not legal BCD below MOD collapse to 00, keeping q always in range.
  function automatic logic [7:0] load_value(input logic [7:0] v);
    int n;
    n = 10 * int'(v[7:4]) + int'(v[3:0]);
    if ((v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (n < MOD)) return v;
    else return 8'h00;
  endfunction

  assign inc     = en & tick & ((EDGE != 0) ? ~tick_q : 1'b1);
  assign at_last = (count_q == {LAST_T, LAST_U});

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = 8'h00;
    end else if (ld) begin
      count_d = load_value(d);
    end else if (inc) begin
      if (at_last) begin
`ifdef TICK_BCD_SAT_EN
        count_d = count_q;
`else
        count_d = 8'h00;
        tc_d    = 1'b1;
`endif
      end else if (count_q[3:0] == 4'd9) begin
        count_d = {count_q[7:4] + 4'd1, 4'd0};
      end else begin
        count_d = {count_q[7:4], count_q[3:0] + 4'd1};
      end
    end
`ifdef TICK_BCD_SAT_EN
    // Saturating mode: tc follows the held terminal value as a level.
    tc_d = (count_d == {LAST_T, LAST_U});
`endif
  end

  // tick_q resets high so a tick already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= 8'h00;
      tc_q    <= 1'b0;
      tick_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      tick_q  <= tick;
    end
  end

  assign q  = count_q;
  assign tc = tc_q;

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Two-digit BCD event counter that consumes the divided clock-enable output (fdclk) of the divide-by-N prescaler stage directly upstream.
- Counts tick events modulo MOD and produces a one-cycle terminal-count pulse for cascading, e.g. seconds into minutes.
- Single clock domain; tick is a synchronous level from the prescaler, never used as a clock.

Parameters:
- MOD, 60, count modulus; legal range 2..100; count sequence is 00..MOD-1 in BCD.
- EDGE, 1, 1 = count rising edges of tick (0->1 transitions); 0 = count every clk cycle in which tick is high.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_b  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear of count and tc.
- en  input  1  count enable; ticks arriving while en=0 are discarded.
- tick  input  1  tick request from prescaler fdclk.
- ld  input  1  synchronous load of d.
- d  input  8  BCD load value {tens[7:4], units[3:0]}.
- q  output  8  current BCD count {tens, units}, registered.
- tc  output  1  terminal-count pulse, registered, one clk wide.

Behaviour:
- Reset (rst_b=0, async): q=8'h00, tc=0, internal tick_q=1. A tick held high out of reset (prescaler count=0 gives fdclk=1) does not count as an edge.
- tick_q <= tick every cycle when rst_b=1, regardless of en, clr and ld.
- Count event: inc = en & tick & (EDGE ? ~tick_q : 1).
- Priority per cycle: clr > ld > inc > hold.
- clr=1: q <= 00, tc <= 0.
- ld=1 (clr=0): q <= d when d is valid BCD (both nibbles <=9) and numeric value < MOD; otherwise q <= 00. tc <= 0. A simultaneous inc is dropped.
- inc=1 (clr=0, ld=0):
  - When q == MOD-1 in BCD: q <= 00, tc <= 1.
  - Else if units == 9: units <= 0, tens <= tens+1, tc <= 0.
  - Else: units <= units+1, tc <= 0.
- Otherwise: q holds, tc <= 0.
- Latency: q updates on the first clk edge after the qualifying tick cycle. tc is high in exactly the cycle q first reads 00 after the wrap.
- MOD=100: terminal value is 99. Tens can never reach 10.
- q must never hold an invalid BCD digit or a value >= MOD, under any input sequence.
- Reset mid-count: async clear of all outputs; counting resumes from 00 on the first qualifying edge after release.
- en deasserted between edges: an edge occurring while en=0 is lost; it is not counted later when en rises.

Optional Feature:
- Macro: TICK_BCD_SAT_EN.
- Defined: saturating mode.
  - At q == MOD-1, further inc leaves q unchanged.
  - tc is asserted as a level (not a pulse) while q == MOD-1.
  - Only clr, ld or reset leave saturation.
- Undefined: wrap-around behaviour with single-cycle tc pulse, as described above.

Test Plan:
- Reset release with tick=1 held, EDGE=1, en=1 -> q stays 8'h00 until tick goes 0 then 1; q=8'h01 one clk after that rising edge.
- Drive tick from prescaler /5 (one-cycle pulse every 5 clk), MOD=60, 60 pulses -> q steps 8'h09 -> 8'h10 -> ... -> 8'h59 -> 8'h00. tc=1 for exactly one cycle, coincident with q=8'h00. No q value has a nibble > 9.
- ld=1 with d=8'h58 -> q=8'h58; next tick -> 8'h59; next -> 8'h00 with tc=1. ld with d=8'h3A or d=8'h75 (MOD=60) -> q=8'h00.
- Same cycle clr=1, ld=1, inc=1 with q=8'h42 -> q=8'h00, tc=0. Same cycle ld=1 (d=8'h20) and inc=1 -> q=8'h20.
- en=0 during 3 tick edges starting from q=8'h07, then en=1 with tick held high -> q=8'h07 (EDGE=1). With EDGE=0, tick held high 4 cycles with en=1 -> q=8'h11.
- TICK_BCD_SAT_EN defined, MOD=10, 12 ticks -> q=8'h09 and tc=1 held. clr -> q=8'h00, tc=0.
